// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl -- steps the DDS tuning word through an evenly spaced list of
// frequencies. At each point it lets the DDS settle, then hands off to the
// capture block with a level request / done handshake.
//
// Ports:
//   CLK, RST        system clock, asynchronous active-high reset
//   Start           begin a sweep (accepted in IDLE only)
//   Abort           stop the sweep at the next edge, no completion pulse
//   KW_Start        tuning word of point 0
//   KW_Step         tuning-word increment between points (wraps mod 2^KW_W)
//   Step_Num        number of points, 0 treated as 1
//   Settle_Cycles   extra settle cycles per point
//   Meas_Done       capture complete, consumed once per MEAS entry
//   KW, SW_Sin_Out  tuning word and sine enable to the DDS core
//   Meas_Req        level request to the capture block
//   Step_Idx        0-based index of the current point
//   Busy            sweep in progress
//   Sweep_Done      one-cycle pulse on normal completion
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for Start, KW keeps the last tuning word
// SETTLE | DDS running at the current point, settle counter running
// MEAS   | Meas_Req high, waiting for Meas_Done
// DONE   | one-cycle completion, Sweep_Done high, DDS disabled

module dds_sweep_ctrl #(
  parameter int KW_W  = 32,
  parameter int IDX_W = 16,
  parameter int SET_W = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Abort,
  input  logic [KW_W-1:0]  KW_Start,
  input  logic [KW_W-1:0]  KW_Step,
  input  logic [IDX_W-1:0] Step_Num,
  input  logic [SET_W-1:0] Settle_Cycles,
  input  logic             Meas_Done,
  output logic [KW_W-1:0]  KW,
  output logic             SW_Sin_Out,
  output logic             Meas_Req,
  output logic [IDX_W-1:0] Step_Idx,
  output logic             Busy,
  output logic             Sweep_Done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_MEAS   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [SET_W-1:0] SET_ONE = SET_W'(1);

  state_t           state_q, state_d;
  logic [KW_W-1:0]  kw_q, kw_d;
  logic             sw_q, sw_d;
  logic             req_q, req_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic [KW_W-1:0]  step_sh_q, step_sh_d;
  logic [IDX_W-1:0] num_sh_q, num_sh_d;
  logic [SET_W-1:0] set_sh_q, set_sh_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      kw_q      <= '0;
      sw_q      <= 1'b0;
      req_q     <= 1'b0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      step_sh_q <= '0;
      num_sh_q  <= '0;
      set_sh_q  <= '0;
    end else begin
      state_q   <= state_d;
      kw_q      <= kw_d;
      sw_q      <= sw_d;
      req_q     <= req_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      step_sh_q <= step_sh_d;
      num_sh_q  <= num_sh_d;
      set_sh_q  <= set_sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kw_d      = kw_q;
    sw_d      = sw_q;
    req_d     = req_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    step_sh_d = step_sh_q;
    num_sh_d  = num_sh_q;
    set_sh_d  = set_sh_q;

    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          step_sh_d = KW_Step;
          num_sh_d  = (Step_Num == '0) ? IDX_ONE : Step_Num;
          set_sh_d  = Settle_Cycles;
          kw_d      = KW_Start;
          idx_d     = '0;
          sw_d      = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = Settle_Cycles;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          req_d   = 1'b1;
          state_d = S_MEAS;
        end else begin
          cnt_d = cnt_q - SET_ONE;
        end
      end
      S_MEAS: begin
        // Leaving MEAS on every accepted Meas_Done means a held-high done
        // still costs a full settle before the next point is taken.
        if (Meas_Done) begin
          req_d = 1'b0;
          if (idx_q == num_sh_q - IDX_ONE) begin
            done_d  = 1'b1;
            sw_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            kw_d    = kw_q + step_sh_q;
            idx_d   = idx_q + IDX_ONE;
            cnt_d   = set_sh_q;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything; KW and Step_Idx keep the point reached.
    if (Abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      kw_d    = kw_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      req_d   = 1'b0;
      sw_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign KW         = kw_q;
  assign SW_Sin_Out = sw_q;
  assign Meas_Req   = req_q;
  assign Step_Idx   = idx_q;
  assign Busy       = busy_q;
  assign Sweep_Done = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and randomized sweeps checked against a
// point-list model (KW of point p = KW_Start + p*KW_Step, request latency
// from the settle count), plus abort, start/abort collision and async reset.

module tb_dds_sweep_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic        Abort;
  logic [31:0] KW_Start;
  logic [31:0] KW_Step;
  logic [15:0] Step_Num;
  logic [23:0] Settle_Cycles;
  logic        Meas_Done;
  logic [31:0] KW;
  logic        SW_Sin_Out;
  logic        Meas_Req;
  logic [15:0] Step_Idx;
  logic        Busy;
  logic        Sweep_Done;

  int n_vec = 0;
  int n_err = 0;

  dds_sweep_ctrl #(.KW_W(32), .IDX_W(16), .SET_W(24)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort),
    .KW_Start(KW_Start), .KW_Step(KW_Step), .Step_Num(Step_Num),
    .Settle_Cycles(Settle_Cycles), .Meas_Done(Meas_Done),
    .KW(KW), .SW_Sin_Out(SW_Sin_Out), .Meas_Req(Meas_Req),
    .Step_Idx(Step_Idx), .Busy(Busy), .Sweep_Done(Sweep_Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Waits for Meas_Req counting cycles from the reference cycle; optionally
  // pulses a spurious Meas_Done in the first settle cycle.
  task automatic wait_req(input int lat, input bit hold, input bit noise_md, output int waited);
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
      if (!hold) Meas_Done = noise_md && (waited == 1);
    end while (Meas_Req !== 1'b1 && waited < lat + 20);
    chk("req_latency", 32'(waited), 32'(lat));
  endtask

  task automatic run_sweep(input logic [31:0] kws, input logic [31:0] kst,
                           input logic [15:0] num, input logic [23:0] st,
                           input int dly, input bit hold, input bit noise);
    int pts;
    int waited;
    logic [31:0] exp_kw;
    pts = (num == 16'd0) ? 1 : int'(num);
    @(negedge CLK);
    KW_Start = kws; KW_Step = kst; Step_Num = num; Settle_Cycles = st;
    Start = 1'b1; Meas_Done = hold;
    for (int p = 0; p < pts; p++) begin
      exp_kw = kws + kst * 32'(p);
      if (p == 0) begin
        // Cycle after the Start edge: scramble inputs, keep Start high if noisy.
        @(negedge CLK);
        chk("start_kw", KW, kws);
        chk("start_busy", Busy, 1'b1);
        Start = noise;
        KW_Start = $urandom; KW_Step = $urandom;
        Step_Num = 16'($urandom); Settle_Cycles = 24'($urandom);
        if (!hold) Meas_Done = noise;
        wait_req(int'(st) + 1, hold, 1'b0, waited);
      end else begin
        wait_req(int'(st) + 1, hold, noise && (st != 0), waited);
      end
      chk("meas_kw", KW, exp_kw);
      chk("meas_idx", Step_Idx, 32'(p));
      chk("meas_sw", SW_Sin_Out, 1'b1);
      for (int k = 0; k < dly; k++) begin
        @(negedge CLK);
        chk("req_hold", Meas_Req, 1'b1);
        chk("kw_stable", KW, exp_kw);
      end
      Meas_Done = 1'b1;
      @(negedge CLK);
      if (!hold) Meas_Done = 1'b0;
      if (p < pts - 1) begin
        chk("adv_req", Meas_Req, 1'b0);
        chk("adv_kw", KW, exp_kw + kst);
        chk("adv_idx", Step_Idx, 32'(p + 1));
        chk("adv_done", Sweep_Done, 1'b0);
      end else begin
        chk("done_pulse", Sweep_Done, 1'b1);
        chk("done_sw", SW_Sin_Out, 1'b0);
        chk("done_busy", Busy, 1'b0);
        chk("done_req", Meas_Req, 1'b0);
        chk("done_kw", KW, exp_kw);
        @(negedge CLK);
        Start = 1'b0; Meas_Done = 1'b0;
        chk("done_once", Sweep_Done, 1'b0);
        chk("final_kw", KW, exp_kw);
        @(negedge CLK);
        chk("idle_busy", Busy, 1'b0);
      end
    end
  endtask

  initial begin
    int waited;
    logic [31:0] kws, kst;
    RST = 1'b1; Start = 1'b0; Abort = 1'b0; Meas_Done = 1'b0;
    KW_Start = '0; KW_Step = '0; Step_Num = '0; Settle_Cycles = '0;
    #12;
    chk("rst_kw", KW, 32'd0);
    chk("rst_sw", SW_Sin_Out, 1'b0);
    chk("rst_req", Meas_Req, 1'b0);
    chk("rst_idx", Step_Idx, 32'd0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Sweep_Done, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    // Basic sweep, Meas_Done two cycles after each request.
    run_sweep(32'h0100_0000, 32'h0010_0000, 16'd3, 24'd4, 2, 1'b0, 1'b0);
    // Step_Num=0 and Settle_Cycles=0: one point, request two cycles after Start.
    run_sweep($urandom, $urandom, 16'd0, 24'd0, 1, 1'b0, 1'b0);
    // Wrap-around of the tuning word.
    run_sweep(32'hFFFF_FF00, 32'h0000_0200, 16'd2, 24'($urandom_range(0, 5)), 1, 1'b0, 1'b0);
    // Start while busy and Meas_Done during settle.
    run_sweep($urandom, $urandom, 16'd3, 24'd3, 1, 1'b0, 1'b1);
    // Meas_Done held high for the whole sweep.
    run_sweep($urandom, $urandom, 16'd4, 24'd2, 0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++)
      run_sweep($urandom, $urandom, 16'($urandom_range(0, 4)), 24'($urandom_range(0, 6)),
                int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));

    // Abort during settle of point 1.
    kws = $urandom; kst = $urandom;
    @(negedge CLK);
    KW_Start = kws; KW_Step = kst; Step_Num = 16'd5; Settle_Cycles = 24'd3; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    wait_req(4, 1'b0, 1'b0, waited);
    Meas_Done = 1'b1;
    @(negedge CLK);
    Meas_Done = 1'b0;
    @(negedge CLK);
    Abort = 1'b1;
    @(negedge CLK);
    Abort = 1'b0;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_sw", SW_Sin_Out, 1'b0);
    chk("abort_req", Meas_Req, 1'b0);
    chk("abort_idx", Step_Idx, 32'd1);
    chk("abort_kw", KW, kws + kst);
    waited = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      waited += int'(Sweep_Done) + int'(Meas_Req) + int'(Busy);
    end
    chk("abort_quiet", 32'(waited), 32'd0);

    // Abort and Start together in IDLE.
    Start = 1'b1; Abort = 1'b1;
    @(negedge CLK);
    Start = 1'b0; Abort = 1'b0;
    chk("abort_start_busy", Busy, 1'b0);
    chk("abort_start_sw", SW_Sin_Out, 1'b0);

    // Abort and Meas_Done together in MEAS.
    kws = $urandom;
    KW_Start = kws; Step_Num = 16'd3; Settle_Cycles = 24'd0; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    wait_req(1, 1'b0, 1'b0, waited);
    Abort = 1'b1; Meas_Done = 1'b1;
    @(negedge CLK);
    Abort = 1'b0; Meas_Done = 1'b0;
    chk("abort_md_idx", Step_Idx, 32'd0);
    chk("abort_md_busy", Busy, 1'b0);
    chk("abort_md_kw", KW, kws);
    chk("abort_md_done", Sweep_Done, 1'b0);

    // Async reset in MEAS clears outputs without a clock edge.
    KW_Start = 32'hA5A5_0001; Step_Num = 16'd2; Settle_Cycles = 24'd1; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    wait_req(2, 1'b0, 1'b0, waited);
    #2 RST = 1'b1;
    #1;
    chk("arst_kw", KW, 32'd0);
    chk("arst_sw", SW_Sin_Out, 1'b0);
    chk("arst_req", Meas_Req, 1'b0);
    chk("arst_busy", Busy, 1'b0);
    chk("arst_idx", Step_Idx, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("arst_after_done", Sweep_Done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep scheduler for the DDS sine generator.
- Sequences the 32-bit tuning word (KW) and the sine-enable switch through a programmed list of evenly spaced frequencies.
- At each frequency it waits a settle time, then hands off to the measurement/capture block through a request/done handshake.
- Sits between the control/key-scan logic and the DDS core; drives the DDS KW and SW_Sin_In inputs directly.

Parameters:
- KW_W, 32, tuning-word width; must equal the DDS phase-accumulator width.
- IDX_W, 16, width of step count and step index.
- SET_W, 24, width of settle-cycle counter.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- Start  in  1  sweep start; sampled in IDLE only
- Abort  in  1  stop sweep immediately; priority over all other inputs
- KW_Start  in  KW_W  first tuning word
- KW_Step  in  KW_W  tuning-word increment per step
- Step_Num  in  IDX_W  number of frequency points; 0 is treated as 1
- Settle_Cycles  in  SET_W  extra settle cycles per point
- Meas_Done  in  1  measurement complete (pulse or level)
- KW  out  KW_W  tuning word to the DDS
- SW_Sin_Out  out  1  sine output enable to the DDS
- Meas_Req  out  1  measurement request, level
- Step_Idx  out  IDX_W  current point index, 0-based
- Busy  out  1  sweep in progress
- Sweep_Done  out  1  one-cycle pulse at normal completion

Behaviour:
- All outputs are registered.
- Reset values: KW=0, SW_Sin_Out=0, Meas_Req=0, Step_Idx=0, Busy=0, Sweep_Done=0, state=IDLE. All shadow registers and counters are cleared.
- Reset mid-sweep takes effect asynchronously: the DDS is disabled at once and no Sweep_Done is issued.
- FSM states: IDLE, SETTLE, MEAS, DONE.
- IDLE:
  - Busy=0. KW holds its last value.
  - Start=1 and Abort=0 at edge t:
    - Latch KW_Step, Step_Num (0 becomes 1) and Settle_Cycles into shadow registers.
    - At t+1: KW=KW_Start, Step_Idx=0, SW_Sin_Out=1, Busy=1, settle counter=Settle_Cycles, state=SETTLE.
  - Input changes after the Start edge do not affect the running sweep.
- SETTLE:
  - Counter=0: Meas_Req<=1, state<=MEAS. Otherwise the counter decrements.
  - SETTLE therefore lasts Settle_Cycles+1 cycles.
  - Meas_Req first goes high Settle_Cycles+2 cycles after the Start edge.
- MEAS:
  - Meas_Req stays high until Meas_Done=1 is sampled.
  - On that edge Meas_Req<=0, and:
    - If Step_Idx == Step_Num_shadow-1: state<=DONE.
    - Otherwise: KW<=KW+KW_Step_shadow (mod 2^KW_W, wrap-around allowed, no saturation), Step_Idx<=Step_Idx+1, counter reload, state<=SETTLE.
  - Step_Idx and KW are stable for the whole of MEAS, so the capture block can tag its result with them.
- DONE:
  - For one cycle: Sweep_Done=1, SW_Sin_Out<=0, Busy<=0.
  - Next state IDLE. KW keeps the final tuning word.
- Meas_Done outside MEAS is ignored.
- A Meas_Done held high causes no double step: each MEAS entry consumes one sampled high.
- Start while Busy=1 is ignored.
- Start in the same cycle as the DONE pulse is ignored. Start is accepted only in IDLE.
- Abort=1 in any non-IDLE state, at the next edge:
  - state=IDLE, Meas_Req=0, SW_Sin_Out=0, Busy=0.
  - No Sweep_Done.
  - KW and Step_Idx hold their values.
- Abort and Start together in IDLE: no sweep starts.
- Abort and Meas_Done together: Abort wins.
- Step_Idx never exceeds Step_Num_shadow-1.

Test Plan:
- Reset → all outputs 0.
- Basic sweep: KW_Start=0x0100_0000, KW_Step=0x0010_0000, Step_Num=3, Settle_Cycles=4; Meas_Done pulses 2 cycles after each Meas_Req.
  - KW sequence: 0x0100_0000, 0x0110_0000, 0x0120_0000; Step_Idx 0,1,2.
  - Meas_Req rises 6 cycles after Start and 5 cycles after each step advance.
  - One Sweep_Done pulse; SW_Sin_Out falls in the DONE cycle; final KW=0x0120_0000.
- Boundaries: Step_Num=0 and Settle_Cycles=0.
  - Exactly one point measured.
  - Meas_Req rises 2 cycles after Start.
  - Sweep_Done follows the first Meas_Done.
- Wrap: KW_Start=0xFFFF_FF00, KW_Step=0x200, Step_Num=2 → second KW=0x0000_0100.
- Abort during SETTLE of point 1 (Step_Num=5) → next cycle Busy=0, SW_Sin_Out=0, Meas_Req=0, no Sweep_Done, Step_Idx=1 held.
- Robustness:
  - Start asserted while busy, and Meas_Done pulsed during SETTLE → no effect on the sequence.
  - Meas_Done held high across a full sweep with Step_Num=4 → exactly 4 points, each with Settle_Cycles+1 settle cycles.
  - Async RST asserted mid-MEAS → outputs clear immediately, without waiting for a clock edge.
